// File: rtl/wager_ledger_if.sv
// Betting/settlement signal bundle between the baccarat round logic and the
// bankroll controller; master drives the requests, slave reports ledger status.
interface wager_ledger_if;
  logic [7:0] wager_in;
  logic [1:0] bet_in;
  logic       load_wager;
  logic       round_done;
  logic [1:0] result;
  logic       betting;
  logic [7:0] balance_out;
  logic [7:0] stake_out;
  logic [1:0] bet_out;
  logic [7:0] payout_out;
  logic       wager_err;
  logic       settled;
  logic       broke;
  logic [7:0] rounds_played;

  modport master (
    output wager_in, bet_in, load_wager, round_done, result,
    input  betting, balance_out, stake_out, bet_out, payout_out,
           wager_err, settled, broke, rounds_played
  );

  modport slave (
    input  wager_in, bet_in, load_wager, round_done, result,
    output betting, balance_out, stake_out, bet_out, payout_out,
           wager_err, settled, broke, rounds_played
  );
endinterface

// File: rtl/wager_ledger.sv
// Baccarat bankroll controller: validates and commits a wager, holds it while
// the round is dealt, then settles the result into a saturating 8-bit balance.
module wager_ledger #(
  parameter logic [7:0] INIT_BALANCE = 8'd100,
  parameter int         TIE_RETURN   = 9
) (
  input logic           slow_clock,
  input logic           resetb,
  wager_ledger_if.slave bus
);

  typedef enum logic [1:0] {ST_BET, ST_LOCKED, ST_SETTLE, ST_BROKE} state_t;

  localparam logic [11:0] TIE_RET12 = 12'(TIE_RETURN);

  state_t     state_q, state_d;
  logic [7:0] balance_q, balance_d;
  logic [7:0] stake_q, stake_d;
  logic [1:0] bet_q, bet_d;
  logic [1:0] result_q, result_d;
  logic [7:0] payout_q, payout_d;
  logic       wager_err_q, wager_err_d;
  logic       settled_q, settled_d;
  logic [7:0] rounds_q, rounds_d;

  logic [11:0] credit;
  logic [12:0] bal_sum;
  logic        wager_ok;

  // Total units returned to the bankroll for the committed bet.
  function automatic logic [11:0] settle_credit(input logic [1:0] bet,
                                                input logic [7:0] stake,
                                                input logic [1:0] res);
    logic [11:0] s12;
    s12 = {4'd0, stake};
    settle_credit = 12'd0;
    if (res == 2'b00)
      settle_credit = s12;
    else if (bet == 2'b11 && res == 2'b11)
      settle_credit = TIE_RET12 * s12;
    else if (bet == res)
      settle_credit = s12 << 1;
    else if (res == 2'b11)
      settle_credit = s12;
  endfunction

  function automatic logic [7:0] sat8(input logic [12:0] v);
    sat8 = (v > 13'd255) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    balance_d   = balance_q;
    stake_d     = stake_q;
    bet_d       = bet_q;
    result_d    = result_q;
    payout_d    = payout_q;
    rounds_d    = rounds_q;
    wager_err_d = 1'b0;
    settled_d   = 1'b0;

    credit   = settle_credit(bet_q, stake_q, result_q);
    bal_sum  = {5'd0, balance_q} + {1'b0, credit};
    wager_ok = (bus.bet_in != 2'b00) && (bus.wager_in != 8'd0) &&
               (bus.wager_in <= balance_q);

    case (state_q)
      ST_BET: begin
        if (bus.load_wager) begin
          if (wager_ok) begin
            balance_d = balance_q - bus.wager_in;
            stake_d   = bus.wager_in;
            bet_d     = bus.bet_in;
            state_d   = ST_LOCKED;
          end else begin
            wager_err_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.round_done) begin
          result_d = bus.result;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        balance_d = sat8(bal_sum);
        payout_d  = sat8({1'b0, credit});
        settled_d = 1'b1;
        rounds_d  = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
        stake_d   = 8'd0;
        bet_d     = 2'b00;
        // A full-balance wager only goes broke if the round pays nothing back.
        state_d   = (sat8(bal_sum) == 8'd0) ? ST_BROKE : ST_BET;
      end
      ST_BROKE: state_d = ST_BROKE;
      default:  state_d = ST_BET;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_BET;
      balance_q   <= INIT_BALANCE;
      stake_q     <= 8'd0;
      bet_q       <= 2'b00;
      result_q    <= 2'b00;
      payout_q    <= 8'd0;
      wager_err_q <= 1'b0;
      settled_q   <= 1'b0;
      rounds_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      balance_q   <= balance_d;
      stake_q     <= stake_d;
      bet_q       <= bet_d;
      result_q    <= result_d;
      payout_q    <= payout_d;
      wager_err_q <= wager_err_d;
      settled_q   <= settled_d;
      rounds_q    <= rounds_d;
    end
  end

  assign bus.betting       = (state_q == ST_BET);
  assign bus.broke         = (state_q == ST_BROKE);
  assign bus.balance_out   = balance_q;
  assign bus.stake_out     = stake_q;
  assign bus.bet_out       = bet_q;
  assign bus.payout_out    = payout_q;
  assign bus.wager_err     = wager_err_q;
  assign bus.settled       = settled_q;
  assign bus.rounds_played = rounds_q;

endmodule

// File: doc/wager_ledger.md
# wager_ledger

Bankroll controller for the baccarat table. It accepts and validates the player's bet and wager during the betting phase, holds the committed stake while a round is dealt, then settles the round result into an 8-bit balance. It sits beside the dealing state machine and the card datapath: it consumes their `load_wager`, round-complete and `result` signals, and supplies `betting`, `balance_out` and status to the LED/HEX display logic.

## Interface
- `INIT_BALANCE`, default 8'd100: balance loaded on reset; must be nonzero.
- `TIE_RETURN`, default 9: total units returned per wagered unit on a winning tie bet (stake plus 8:1).
- `slow_clock` in 1: the single clock, rising-edge.
- `resetb` in 1: asynchronous, active-low reset.
- `wager_in` in 8: requested wager, unsigned.
- `bet_in` in 2: bet type. 00 none, 01 player, 10 banker, 11 tie.
- `load_wager` in 1: one-cycle request to commit `bet_in`/`wager_in`.
- `round_done` in 1: one-cycle strobe; `result` is valid this cycle.
- `result` in 2: 00 void, 01 player wins, 10 banker wins, 11 tie.
- `betting` out 1: high in the BET state only.
- `balance_out` out 8: current balance.
- `stake_out` out 8: committed wager; 0 when none is committed.
- `bet_out` out 2: committed bet type; 00 when none is committed.
- `payout_out` out 8: credit from the last settlement, saturated at 255.
- `wager_err` out 1: one-cycle pulse when a wager is rejected.
- `settled` out 1: one-cycle pulse when a settlement is applied.
- `broke` out 1: high in the BROKE state.
- `rounds_played` out 8: count of settled rounds, saturating at 255.

## Operation
- States are BET, LOCKED, SETTLE and BROKE. Outputs are Moore-style: `betting` = (state==BET) and `broke` = (state==BROKE).
- **BET**
  - A valid wager is `load_wager`=1, `bet_in`≠00 and 1 ≤ `wager_in` ≤ `balance_out`.
  - On a valid wager: balance ← balance − wager_in; `stake_out` ← wager_in; `bet_out` ← bet_in; go to LOCKED.
  - On an invalid wager: `wager_err` pulses, all registers hold, stay in BET.
  - `round_done` is ignored in BET.
- **LOCKED**
  - On `round_done`=1: latch `result` and go to SETTLE.
  - `load_wager` is ignored in LOCKED.
- **SETTLE** (exactly one cycle)
  - The 12-bit credit is computed from the latched bet, stake and result:
    - result 00 (void): credit = stake.
    - bet matches result, bet 01 or 10: credit = 2·stake.
    - bet 11 and result 11: credit = TIE_RETURN·stake.
    - bet 01 or 10 and result 11 (push): credit = stake.
    - Otherwise: credit = 0.
  - Balance update: balance ← min(255, balance + credit), computed at 13 bits.
  - Other updates: `payout_out` ← min(255, credit); `settled` pulses; `rounds_played` increments, saturating at 255; `stake_out` and `bet_out` clear to 0.
  - Next state: BROKE if the new balance is 0, else BET.
- **BROKE**
  - Terminal state. All inputs are ignored until reset.
- **Reset** (asynchronous, any state, including mid-round)
  - State goes to BET and balance to INIT_BALANCE.
  - `stake_out`, `bet_out`, `payout_out`, `rounds_played`, `wager_err` and `settled` all go to 0.
  - The stake of an interrupted round is not refunded separately; the balance simply reinitialises.

## Timing
- All registers update on the rising edge of `slow_clock`.
- `wager_err`, `settled` and the updates to balance, stake and payout become visible after the edge that samples the triggering input or leaves SETTLE.
- Latency:
  - Accepted `load_wager` to `betting`=0 and deducted balance: 1 edge.
  - `round_done` to SETTLE: 1 edge.
  - SETTLE to updated balance with `settled`=1: 1 more edge, so 2 edges after `round_done`.
- Pulses last exactly one cycle. Holding `load_wager` high in BET after an accept has no effect, because the block is already in LOCKED.
- A wager equal to the full balance is legal and leaves a balance of 0 while LOCKED. The BROKE check happens only at settlement.
- Reset values: `betting`=1, `balance_out`=INIT_BALANCE, `broke`=0; all other outputs 0.

## Test plan
- Player win:
  - Stimulus: reset, then bet 01 with wager 20, then `round_done` with result 01.
  - Required: balance 100 → 80 (LOCKED) → 120; `payout_out`=40; `settled` pulses once; `rounds_played`=1.
- Tie bet and saturation:
  - Stimulus: from balance 100, bet 11 with wager 30, then result 11.
  - Required: credit 270; balance = min(255, 70+270) = 255; `payout_out`=255.
- Rejections:
  - Stimulus 1: wager 0. Stimulus 2: wager 101 with balance 100. Stimulus 3: bet 00 with wager 10.
  - Required for each: `wager_err` pulses for one cycle, balance stays 100, state stays BET.
- Push and broke:
  - Push stimulus: bet 10 with wager 50, then result 11.
  - Push required: balance returns to 100.
  - Broke stimulus: bet 01 with wager 100, then result 10.
  - Broke required: balance 0; `broke`=1; `betting`=0; later `load_wager` pulses have no effect.
- Ignored events:
  - Stimulus 1: `round_done` while in BET. Stimulus 2: `load_wager` while LOCKED.
  - Required: no state or balance change in either case.
- Reset mid-round:
  - Stimulus: assert `resetb`=0 while LOCKED with stake 40.
  - Required: immediately, without waiting for a clock edge: balance 100, `stake_out`=0, `betting`=1.
